top_memory_access: RTL and testbench

//  Memory-access stage; sits directly downstream of the execute stage.

---
 rtl/top_memory_access_pkg.sv | 19 +
 rtl/top_memory_access_mem_align.sv | 59 +++++
 rtl/top_memory_access.sv | 187 ++++++++++++++++++
 tb/tb_top_memory_access.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_memory_access_pkg.sv
// Shared constants for the memory-access stage: opcode bit positions, funct3 codes, FSM states.
package top_memory_access_pkg;

  localparam int OPLEN_DEF = 8;
  localparam int LOAD_BIT  = 0;
  localparam int STORE_BIT = 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/top_memory_access_mem_align.sv
// Combinational lane logic: store byte enables and data replication, load lane select
// and extension, and the misalignment / undefined-funct3 flag.
module top_memory_access_mem_align
  import top_memory_access_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [31:0] lane;

  always_comb begin
    lane        = rdata_i >> {addr_lo_i, 3'b000};
    be_o        = 4'b0000;
    wdata_o     = '0;
    load_data_o = '0;
    misalign_o  = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{rs2_i[7:0]}};
        load_data_o = {{24{lane[7]}}, lane[7:0]};
      end
      F3_H: begin
        misalign_o  = addr_lo_i[0];
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{rs2_i[15:0]}};
        load_data_o = {{16{lane[15]}}, lane[15:0]};
      end
      F3_W: begin
        misalign_o  = |addr_lo_i;
        be_o        = 4'b1111;
        wdata_o     = rs2_i;
        load_data_o = rdata_i;
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        misalign_o  = is_store_i;
        load_data_o = {24'd0, lane[7:0]};
      end
      F3_HU: begin
        misalign_o  = is_store_i | addr_lo_i[0];
        load_data_o = {16'd0, lane[15:0]};
      end
      default: misalign_o = 1'b1;
    endcase
    if (!is_store_i) begin
      be_o = 4'b1111;
    end
  end

endmodule

// File: rtl/top_memory_access.sv
// RV32 memory-access stage: issues one req/ack data-memory transaction per load/store,
// stalls while it is outstanding, and latches the writeback bundle at completion.
module top_memory_access
  import top_memory_access_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OPLEN       = OPLEN_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memory,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [2:0]       funct_mem_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic             jump_state_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic             jump_state_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  load_data_mw,
  output logic             mem_err_mw,
  output logic             stall_memory
);

  typedef struct packed {
    logic [OPLEN-1:0] op;
    logic [4:0]       rd;
    logic [XLEN-1:0]  pc;
    logic             jump;
    logic [XLEN-1:0]  alu;
  } stage_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  stage_t          cap_q, cap_d;
  logic [2:0]      f3_q, f3_d;
  stage_t          mw_q, mw_d;
  logic [XLEN-1:0] load_q, load_d;
  logic            err_q, err_d;

  stage_t          em;
  logic            wait_st, is_store, memop, timeout, start;
  logic            al_store;
  logic [2:0]      al_f3;
  logic [1:0]      al_addr;
  logic [3:0]      al_be;
  logic [31:0]     al_wdata, al_load;
  logic            al_misalign;

  assign em       = {decoded_op_em, rdsel_em, next_pc_em, jump_state_em, alu_out_em};
  assign wait_st  = (state_q == ST_WAIT);
  assign is_store = decoded_op_em[STORE_BIT];
  assign memop    = decoded_op_em[LOAD_BIT] | decoded_op_em[STORE_BIT];

  // While waiting, the aligner decodes the captured instruction so the load result
  // does not depend on the execute latch staying stable.
  assign al_store = wait_st ? cap_q.op[STORE_BIT] : is_store;
  assign al_f3    = wait_st ? f3_q : funct_mem_em;
  assign al_addr  = wait_st ? cap_q.alu[1:0] : alu_out_em[1:0];

  top_memory_access_mem_align u_align (
    .is_store_i  (al_store),
    .funct3_i    (al_f3),
    .addr_lo_i   (al_addr),
    .rs2_i       (rs2data_em),
    .rdata_i     (dmem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .load_data_o (al_load),
    .misalign_o  (al_misalign)
  );

  assign timeout      = wait_st & ~dmem_ack & (cnt_q == CNT_LAST);
  assign start        = ~wait_st & phase_memory & memop & ~al_misalign;
  assign stall_memory = ~rst & (start | (wait_st & ~dmem_ack & ~timeout));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    f3_d    = f3_q;
    mw_d    = mw_q;
    load_d  = load_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (phase_memory) begin
          if (!memop || al_misalign) begin
            mw_d   = em;
            load_d = '0;
            err_d  = memop;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {alu_out_em[XLEN-1:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
            cap_d   = em;
            f3_d    = funct_mem_em;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_ack || timeout) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          mw_d    = cap_q;
          err_d   = ~dmem_ack;
          load_d  = (dmem_ack && cap_q.op[LOAD_BIT] && !cap_q.op[STORE_BIT]) ? al_load : '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      f3_q    <= '0;
      mw_q    <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      f3_q    <= f3_d;
      mw_q    <= mw_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign decoded_op_mw = mw_q.op;
  assign rdsel_mw      = mw_q.rd;
  assign next_pc_mw    = mw_q.pc;
  assign jump_state_mw = mw_q.jump;
  assign alu_out_mw    = mw_q.alu;
  assign load_data_mw  = load_q;
  assign mem_err_mw    = err_q;

endmodule

// File: tb/tb_top_memory_access.sv
// Randomized bench for top_memory_access: acts as state machine and data memory, and
// compares every transaction against a transaction-level reference model.
module tb_top_memory_access;

  localparam int OPL = top_memory_access_pkg::OPLEN_DEF;
  localparam int TO  = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           phase_memory = 1'b0;
  logic [OPL-1:0] decoded_op_em = '0;
  logic [2:0]     funct_mem_em = '0;
  logic [4:0]     rdsel_em = '0;
  logic [31:0]    next_pc_em = '0;
  logic           jump_state_em = 1'b0;
  logic [31:0]    alu_out_em = '0;
  logic [31:0]    rs2data_em = '0;
  logic           dmem_req, dmem_we;
  logic [31:0]    dmem_addr, dmem_wdata;
  logic [3:0]     dmem_be;
  logic           dmem_ack = 1'b0;
  logic [31:0]    dmem_rdata = '0;
  logic [OPL-1:0] decoded_op_mw;
  logic [4:0]     rdsel_mw;
  logic [31:0]    next_pc_mw, alu_out_mw, load_data_mw;
  logic           jump_state_mw, mem_err_mw, stall_memory;

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  always #5 clk = ~clk;

  top_memory_access #(.XLEN(32), .OPLEN(OPL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .phase_memory(phase_memory),
    .decoded_op_em(decoded_op_em), .funct_mem_em(funct_mem_em), .rdsel_em(rdsel_em),
    .next_pc_em(next_pc_em), .jump_state_em(jump_state_em), .alu_out_em(alu_out_em),
    .rs2data_em(rs2data_em),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .decoded_op_mw(decoded_op_mw), .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw),
    .jump_state_mw(jump_state_mw), .alu_out_mw(alu_out_mw), .load_data_mw(load_data_mw),
    .mem_err_mw(mem_err_mw), .stall_memory(stall_memory)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Access size in bytes from funct3; 0 marks an undefined code.
  function automatic int size_of(input logic [2:0] f3, input logic st);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return st ? 0 : 1;
      3'd5: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    int v;
    case (f3)
      3'd0: begin v = int'((w >> (8 * a)) & 32'hFF);   if (v > 127)   v -= 256;   end
      3'd1: begin v = int'((w >> (8 * a)) & 32'hFFFF); if (v > 32767) v -= 65536; end
      3'd4: v = int'((w >> (8 * a)) & 32'hFF);
      3'd5: v = int'((w >> (8 * a)) & 32'hFFFF);
      default: v = int'(w);
    endcase
    return 32'(v);
  endfunction

  // Starts just after a rising edge; one instruction through the stage, then checks.
  task automatic run_txn(input logic [OPL-1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int delay);
    logic st, ld, mem, bad, req_exp, err_e, done;
    logic [3:0] be_e;
    logic [31:0] wd_e, ld_e;
    logic [4:0] rd;
    logic [31:0] pc;
    logic jmp;
    int nb, wait_n, stall_e, req_e, stall_n, req_n;

    rd = 5'($urandom); pc = $urandom; jmp = 1'($urandom);
    st  = op[1];
    ld  = op[0] & ~op[1];
    mem = op[0] | op[1];
    nb  = size_of(f3, st);
    bad = mem && ((nb == 0) || ((int'(alu[1:0]) % nb) != 0));
    req_exp = mem && !bad;
    wait_n  = (delay < TO) ? delay : TO - 1;
    stall_e = req_exp ? 1 + wait_n : 0;
    req_e   = req_exp ? 1 + wait_n : 0;
    err_e   = bad || (req_exp && delay >= TO);
    be_e    = !st ? 4'hF : (nb == 1) ? 4'(1 << alu[1:0]) : (nb == 2) ? 4'(3 << alu[1:0]) : 4'hF;
    wd_e    = (nb == 1) ? rs2[7:0] * 32'h01010101 : (nb == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    ld_e    = (ld && req_exp && !err_e) ? ref_load(f3, alu[1:0], rdata) : 32'd0;

    decoded_op_em = op; funct_mem_em = f3; rdsel_em = rd; next_pc_em = pc;
    jump_state_em = jmp; alu_out_em = alu; rs2data_em = rs2; phase_memory = 1'b1;
    done = 1'b0; stall_n = 0; req_n = 0;
    for (int c = 0; c < TO + 8 && !done; c++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        chk("req_addr", dmem_addr, {alu[31:2], 2'b00});
        chk("req_we", dmem_we, st);
        chk("req_be", dmem_be, be_e);
        if (st) chk("req_wdata", dmem_wdata, wd_e);
        if (req_n == delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
        req_n++;
      end
      #1;
      if (stall_memory) stall_n++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    phase_memory = 1'b0;
    chk("completed", done, 1'b1);
    chk("stall_cycles", stall_n, stall_e);
    chk("req_cycles", req_n, req_e);
    chk("op_mw", decoded_op_mw, op);
    chk("rd_mw", rdsel_mw, rd);
    chk("pc_mw", next_pc_mw, pc);
    chk("jump_mw", jump_state_mw, jmp);
    chk("alu_mw", alu_out_mw, alu);
    chk("load_mw", load_data_mw, ld_e);
    chk("err_mw", mem_err_mw, err_e);
    // Scramble the execute latch with phase low: the writeback bundle must hold.
    decoded_op_em = OPL'($urandom); alu_out_em = $urandom; rdsel_em = 5'($urandom);
    @(negedge clk);
    chk("req_dropped", dmem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_alu_mw", alu_out_mw, alu);
    chk("hold_load_mw", load_data_mw, ld_e);
    $display("txn %0d op=%h f3=%0d addr=%h delay=%0d stalls=%0d err=%0d load=%h",
             n_txn, op, f3, alu, delay, stall_n, mem_err_mw, load_data_mw);
    n_txn++;
  endtask

  initial begin
    logic [OPL-1:0] op;
    logic [2:0] f3;
    int kind, dsel, delay;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall_memory, 1'b0);
    chk("rst_alu_mw", alu_out_mw, 32'd0);
    chk("rst_err_mw", mem_err_mw, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_txn(8'h40, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 0);
    run_txn(8'h02, 3'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 3);
    run_txn(8'h01, 3'd0, 32'h0000_0102, 32'h0, 32'h0080_FF00, 1);
    run_txn(8'h01, 3'd4, 32'h0000_0102, 32'h0, 32'h0080_FF00, 2);
    run_txn(8'h01, 3'd1, 32'h0000_0101, 32'h0, 32'h0, 0);
    run_txn(8'h01, 3'd2, 32'h0000_0200, 32'h0, 32'h1234_5678, 1000);

    // A late ack after the timeout must not disturb anything.
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_stall", stall_memory, 1'b0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_load", load_data_mw, 32'd0);
    chk("late_ack_err", mem_err_mw, 1'b1);

    // Reset while a load is outstanding.
    decoded_op_em = 8'h01; funct_mem_em = 3'd2; alu_out_em = 32'h0000_0300; phase_memory = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", dmem_req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    phase_memory = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wait_req", dmem_req, 1'b0);
    chk("rst_wait_op_mw", decoded_op_mw, 8'd0);
    chk("rst_wait_rd_mw", rdsel_mw, 5'd0);
    chk("rst_wait_pc_mw", next_pc_mw, 32'd0);
    chk("rst_wait_jump_mw", jump_state_mw, 1'b0);
    chk("rst_wait_alu_mw", alu_out_mw, 32'd0);
    chk("rst_wait_load_mw", load_data_mw, 32'd0);
    chk("rst_wait_err_mw", mem_err_mw, 1'b0);
    run_txn(8'h01, 3'd2, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 2);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        op = OPL'($urandom) & ~OPL'(3);
        f3 = 3'($urandom);
      end else if (kind == 1) begin
        op = (OPL'($urandom) & ~OPL'(3)) | OPL'(1);
        f3 = 3'($urandom);
      end else begin
        op = (OPL'($urandom) & ~OPL'(3)) | OPL'(2);
        f3 = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      end
      dsel = $urandom_range(0, 9);
      delay = (dsel < 7) ? $urandom_range(0, 4) : (dsel == 7) ? TO - 1 : (dsel == 8) ? TO : TO + 5;
      run_txn(op, f3, $urandom, $urandom, $urandom, delay);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
